// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd core and its job sequencer: the operand
// width the core is built for and the sequencer FSM state encoding.
package gcd_pkg;

   localparam int GCD_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } gcd_state_e;

endpackage

// File: rtl/gcd_op_fifo.sv
// Operand-pair FIFO in front of the gcd core. Power-of-two depth; the
// pointers carry one extra bit so full and empty can be told apart when the
// index bits are equal.
module gcd_op_fifo
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [2*WIDTH-1:0]   wdata,
   output logic [2*WIDTH-1:0]   rdata,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(DEPTH);

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   // Advance the read and write pointers; both wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: every clocked assignment is non-blocking so all registers
         // update together from values sampled before the edge.
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Write the incoming operand pair into the slot at the write pointer.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately left out of reset; the pointers alone
      // decide which entries are valid, so stale contents are never read.
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds operand pairs to the subtractive gcd core one job at a time and
// returns each result on a valid/ready stream. Zero operands are resolved
// here because the core would never terminate on them.
module gcd_job_sequencer
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] gcd_a,
   output logic [WIDTH-1:0] gcd_b,
   output logic             gcd_go,
   input  logic             gcd_done,
   input  logic [WIDTH-1:0] gcd_ans,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_ans,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_err,
   output logic             busy,
   output logic [CNT_W-1:0] job_count
);

   gcd_state_e         state;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [2*WIDTH-1:0] head;
   logic [WIDTH-1:0]   head_a;
   logic [WIDTH-1:0]   head_b;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign head_a    = head[2*WIDTH-1:WIDTH];
   assign head_b    = head[WIDTH-1:0];

   gcd_op_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({in_a, in_b}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Go is a one-cycle pulse because ISSUE always lasts exactly one cycle.
   assign gcd_go    = (state == ISSUE);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE) || !fifo_empty;

   // Job FSM: pop, zero bypass or core issue, wait for done, hold result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gcd_a     <= '0;
         gcd_b     <= '0;
         out_ans   <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_err   <= 1'b0;
         job_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  gcd_a <= head_a;
                  gcd_b <= head_b;
                  if (head_a == '0 || head_b == '0) begin
                     // gcd(0,x) = x; gcd(0,0) is undefined and flagged.
                     out_a   <= head_a;
                     out_b   <= head_b;
                     out_ans <= head_a | head_b;
                     out_err <= (head_a == '0) && (head_b == '0);
                     state   <= OUT;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (gcd_done) begin
                  out_a   <= gcd_a;
                  out_b   <= gcd_b;
                  out_ans <= gcd_ans;
                  out_err <= 1'b0;
                  state   <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  job_count <= job_count + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: a behavioural gcd core, a scoreboard of
// accepted jobs checked every cycle, and directed jobs with literal results.
module tb_gcd_job_sequencer;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic [W-1:0]  gcd_a;
   logic [W-1:0]  gcd_b;
   logic          gcd_go;
   logic          gcd_done;
   logic [W-1:0]  gcd_ans;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_ans;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic          out_err;
   logic          busy;
   logic [CW-1:0] job_count;
   logic          inject_done = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int go_count = 0;

   gcd_job_sequencer #(
      .WIDTH (W),
      .DEPTH (4),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .gcd_a     (gcd_a),
      .gcd_b     (gcd_b),
      .gcd_go    (gcd_go),
      .gcd_done  (gcd_done),
      .gcd_ans   (gcd_ans),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ans   (out_ans),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_err   (out_err),
      .busy      (busy),
      .job_count (job_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Euclid by remainder; gcd(0,x)=x and gcd(0,0)=0 fall out naturally.
   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      int x = int'(a);
      int y = int'(b);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x[W-1:0];
   endfunction

   // Cycle cost of a subtractive core, used as the model core's latency.
   function automatic int sub_steps(input logic [W-1:0] a, input logic [W-1:0] b);
      int x = int'(a);
      int y = int'(b);
      int n = 1;
      if (x == 0 || y == 0) return 1;
      while (x != y && n < 4000) begin
         if (x > y) x = x - y;
         else       y = y - x;
         n++;
      end
      return n;
   endfunction

   // Behavioural gcd core; inject_done forces a stray done with junk data.
   int           core_cnt;
   logic [W-1:0] core_res;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         gcd_done <= 1'b0;
         gcd_ans  <= '0;
         core_cnt <= 0;
         core_res <= '0;
      end else begin
         gcd_done <= 1'b0;
         if (inject_done) begin
            gcd_done <= 1'b1;
            gcd_ans  <= 16'hDEAD;
         end
         if (gcd_go) begin
            core_cnt <= sub_steps(gcd_a, gcd_b);
            core_res <= ref_gcd(gcd_a, gcd_b);
         end else if (core_cnt == 1) begin
            gcd_done <= 1'b1;
            gcd_ans  <= core_res;
            core_cnt <= 0;
         end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // Scoreboard: every accepted pair is an outstanding job until handshaken.
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] ans;
      logic         err;
   } job_t;

   job_t exp_q[$];
   int   mdl_count = 0;
   logic core_busy = 1'b0;
   logic prev_done = 1'b0;

   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         exp_q.delete();
         mdl_count = 0;
         core_busy = 1'b0;
         prev_done = 1'b0;
         check("rst_out_valid", out_valid, 0);
         check("rst_job_count", job_count, 0);
      end else begin
         check("job_count", job_count, mdl_count);
         check("busy", busy, exp_q.size() != 0);
         if (prev_done) check("done_to_valid", out_valid, 1);
         if (core_busy && !gcd_go && exp_q.size() != 0) begin
            check("wait_gcd_a", gcd_a, exp_q[0].a);
            check("wait_gcd_b", gcd_b, exp_q[0].b);
         end
         prev_done = core_busy && gcd_done && !out_valid;
         if (prev_done) core_busy = 1'b0;
         if (gcd_go) begin
            go_count++;
            if (exp_q.size() == 0) begin
               check("spurious_go", gcd_go, 0);
            end else begin
               check("go_gcd_a", gcd_a, exp_q[0].a);
               check("go_gcd_b", gcd_b, exp_q[0].b);
               check("go_zero_operand", (exp_q[0].a == 0) || (exp_q[0].b == 0), 0);
               check("go_while_valid", out_valid, 0);
            end
            core_busy = 1'b1;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", out_valid, 0);
            end else begin
               check("sb_out_ans", out_ans, exp_q[0].ans);
               check("sb_out_a", out_a, exp_q[0].a);
               check("sb_out_b", out_b, exp_q[0].b);
               check("sb_out_err", out_err, exp_q[0].err);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  mdl_count = (mdl_count + 1) % (1 << CW);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{a: in_a, b: in_b, ans: ref_gcd(in_a, in_b),
                              err: (in_a == 0) && (in_b == 0)});
         end
      end
   end

   // Offer one pair starting at a falling edge; returns at the falling edge
   // after it was accepted.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #2;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!in_ready) check("push_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for a result, check it literally, poke a stray done while it is
   // held, then handshake it. Called at a falling edge with out_ready low.
   task automatic take_result(input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic [W-1:0] eans, input logic eerr,
                              input int ecount, output int lat);
      int n = 0;
      #2;
      while (!out_valid && n < 2000) begin
         @(negedge clk);
         #2;
         n++;
      end
      lat = n;
      check("res_valid", out_valid, 1);
      check("res_ans", out_ans, eans);
      check("res_a", out_a, ea);
      check("res_b", out_b, eb);
      check("res_err", out_err, eerr);
      @(negedge clk);
      inject_done = 1'b1;
      @(negedge clk);
      inject_done = 1'b0;
      @(negedge clk);
      #2;
      check("hold_valid", out_valid, 1);
      check("hold_ans", out_ans, eans);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #2;
      check("res_count", job_count, ecount);
      check("res_valid_drop", out_valid, 0);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int g0;
      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_gcd_go", gcd_go, 0);
      check("reset_gcd_a", gcd_a, 0);
      check("reset_out_ans", out_ans, 0);
      check("reset_out_err", out_err, 0);
      check("reset_job_count", job_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      check("pin_gcd_48_18", ref_gcd(16'd48, 16'd18), 6);
      check("pin_gcd_100_75", ref_gcd(16'd100, 16'd75), 25);
      check("pin_gcd_0_7", ref_gcd(16'd0, 16'd7), 7);

      // Core path.
      g0 = go_count;
      push(16'd48, 16'd18);
      take_result(16'd48, 16'd18, 16'd6, 1'b0, 1, lat);
      check("t1_go_pulses", go_count - g0, 1);

      // Zero bypass, one operand zero.
      g0 = go_count;
      push(16'd0, 16'd7);
      take_result(16'd0, 16'd7, 16'd7, 1'b0, 2, lat);
      check("t2a_latency", lat, 1);
      push(16'd9, 16'd0);
      take_result(16'd9, 16'd0, 16'd9, 1'b0, 3, lat);
      check("t2b_latency", lat, 1);
      check("t2_no_go", go_count - g0, 0);

      // Both operands zero, then a normal job.
      g0 = go_count;
      push(16'd0, 16'd0);
      take_result(16'd0, 16'd0, 16'd0, 1'b1, 4, lat);
      check("t3_latency", lat, 1);
      check("t3_no_go", go_count - g0, 0);
      push(16'd12, 16'd8);
      take_result(16'd12, 16'd8, 16'd4, 1'b0, 5, lat);

      // Backpressure: one job held in OUT, four filling the FIFO.
      push(16'd21, 16'd14);
      push(16'd35, 16'd10);
      push(16'd17, 16'd5);
      push(16'd100, 16'd75);
      push(16'd64, 16'd48);
      #2;
      check("t4_full_in_ready", in_ready, 0);
      check("t4_busy", busy, 1);
      @(negedge clk);
      take_result(16'd21, 16'd14, 16'd7, 1'b0, 6, lat);
      take_result(16'd35, 16'd10, 16'd5, 1'b0, 7, lat);
      take_result(16'd17, 16'd5, 16'd1, 1'b0, 8, lat);
      take_result(16'd100, 16'd75, 16'd25, 1'b0, 9, lat);
      take_result(16'd64, 16'd48, 16'd16, 1'b0, 10, lat);

      // Reset while the core is grinding on a long job with two queued.
      g0 = go_count;
      push(16'd1000, 16'd3);
      push(16'd5, 16'd5);
      push(16'd8, 16'd2);
      repeat (10) @(negedge clk);
      check("t5_in_wait", go_count - g0, 1);
      rst = 1'b0;
      #1;
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_in_ready", in_ready, 1);
      check("t5_rst_gcd_go", gcd_go, 0);
      check("t5_rst_gcd_a", gcd_a, 0);
      check("t5_rst_gcd_b", gcd_b, 0);
      check("t5_rst_out_ans", out_ans, 0);
      check("t5_rst_out_a", out_a, 0);
      check("t5_rst_out_b", out_b, 0);
      check("t5_rst_job_count", job_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      check("t5_no_stale_valid", out_valid, 0);
      check("t5_idle_busy", busy, 0);
      @(negedge clk);
      push(16'd6, 16'd4);
      take_result(16'd6, 16'd4, 16'd2, 1'b0, 1, lat);

      // Drive job_count across its wrap with zero-path jobs.
      for (int k = 1; k <= 14; k++) begin
         push(16'd0, W'(k));
         take_result(16'd0, W'(k), W'(k), 1'b0, (1 + k) % 16, lat);
      end
      check("t6_count_top", job_count, 15);
      push(16'd7, 16'd0);
      take_result(16'd7, 16'd0, 16'd7, 1'b0, 0, lat);
      check("t6_count_wrapped", job_count, 0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule
